// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the RV32I multi-cycle control sequencer.
// Holds the state encodings, the trap cause codes and the rule that
// decides whether a decoded instruction needs the data memory phase.
package core_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6,
    ST_TRAP    = 3'd7
  } state_e;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Writeback source code the decoder uses for loads.
  localparam logic [1:0] SEL_LOAD = 2'b01;

  function automatic logic is_mem_op(input logic mem_we, input logic [1:0] sel);
    return mem_we || (sel == SEL_LOAD);
  endfunction

endpackage

// File: rtl/core_sequencer_mem_watchdog.sv
// Bus wait watchdog for the shared memory port.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clear_i     - state is changing this cycle; restart the count
//   inc_i       - a memory request is pending without mem_ready
//   expired_o   - the count has reached TIMEOUT
module mem_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over increment: the count always belongs to the current state.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I core. Sequences fetch, decode,
// execute, memory and writeback, arbitrates the single memory port,
// gates the decoder write enables, counts retired instructions and traps
// on illegal opcodes or a stalled bus.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   dec_*                 - combinational decoder outputs for the current IR
//   mem_ready             - memory completes the current request
//   halt_req              - stop after the current instruction retires
//   mem_req/addr_sel/we   - shared memory port control
//   ir_load, reg_we, pc_we- one-cycle commit strobes
//   halted, trap, trap_cause, instret - status
//
// state      | meaning
// IDLE       | after reset, go fetch
// FETCH      | instruction read on memory port (address = PC)
// DECODE     | register-file read, opcode legality check
// EXECUTE    | ALU cycle, choose MEM or WB
// MEM        | load/store on memory port (address = ALU result)
// WB         | commit reg write and next PC, count retirement
// HALT       | stopped while halt_req is held
// TRAP       | sticky fault, left only by reset
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic        dec_reg_we,
  input  logic        dec_mem_we,
  input  logic [1:0]  dec_reg_sel_data_in,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        mem_req,
  output logic        mem_addr_sel,
  output logic        mem_we,
  output logic        ir_load,
  output logic        reg_we,
  output logic        pc_we,
  output logic        halted,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] instret_q, instret_d;
  logic        expired;
  logic        wait_inc;

  assign wait_inc = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;

  mem_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_d != state_q),
    .inc_i     (wait_inc),
    .expired_o (expired)
  );

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    instret_d    = instret_q;
    mem_req      = 1'b0;
    mem_addr_sel = 1'b0;
    mem_we       = 1'b0;
    ir_load      = 1'b0;
    reg_we       = 1'b0;
    pc_we        = 1'b0;
    halted       = 1'b0;
    trap         = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        // A ready in the expiry cycle still completes the fetch.
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (!dec_valid) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        state_d = is_mem_op(dec_mem_we, dec_reg_sel_data_in) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = dec_mem_we;
        if (mem_ready) begin
          state_d = ST_WB;
        end else if (expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_WB: begin
        reg_we    = dec_reg_we;
        pc_we     = 1'b1;
        instret_d = instret_q + 32'd1;
        state_d   = halt_req ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (!halt_req) begin
          state_d = ST_FETCH;
        end
      end
      ST_TRAP: trap = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule
